hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard_pkg.sv | 37 +++
 rtl/hazard_scoreboard_fwd_port.sv | 62 ++++++
 rtl/hazard_scoreboard.sv | 114 +++++++++++
 tb/tb_hazard_scoreboard.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared definitions for the hazard scoreboard.
// Holds the stage-index constants, the register-address width, the
// per-stage entry record and a helper that clamps an issue-time ready
// stage into the legal range 1..depth.
package hazard_scoreboard_pkg;

    localparam int AW   = 5;   // register address width
    localparam int RDYW = 3;   // ready-stage field width

    localparam logic [RDYW-1:0] STG_EX  = 3'd1;
    localparam logic [RDYW-1:0] STG_MEM = 3'd2;
    localparam logic [RDYW-1:0] STG_WB  = 3'd3;

    // One tracked in-flight instruction.
    typedef struct packed {
        logic            v;      // slot holds a live instruction
        logic            we;     // instruction writes a register
        logic [AW-1:0]   waddr;  // destination register
        logic [RDYW-1:0] rdy;    // first stage whose stage_wdata carries the result
    } entry_t;

    // A ready stage of 0 means "available from EX"; anything beyond the
    // last tracked stage is pinned to that last stage.
    function automatic logic [RDYW-1:0] norm_rdy(input logic [RDYW-1:0] rdy,
                                                 input logic [RDYW-1:0] depth);
        logic [RDYW-1:0] res;
        if (rdy == 3'd0) begin
            res = STG_EX;
        end else if (rdy > depth) begin
            res = depth;
        end else begin
            res = rdy;
        end
        return res;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_fwd_port.sv
// hs_fwd_port: forwarding select for one operand read port.
// Finds the youngest tracked entry writing the requested register and
// either bypasses that stage's result or flags a load-use hazard when the
// result is not produced yet.
// Ports:
//   entries     in  DEPTH entries, index 0 = stage 1 (EX)
//   rd_en       in  port read enable
//   rd_addr     in  source register
//   rf_rdata    in  register-file data for this port
//   stage_wdata in  result bus of every stage, slice k-1 = stage k
//   op_rdata    out forwarded operand
//   hazard      out youngest match is not ready yet
module hs_fwd_port
    import hazard_scoreboard_pkg::*;
#(
    parameter int DEPTH = 3,
    parameter int DW    = 32
) (
    input  entry_t [DEPTH-1:0]    entries,
    input  logic                  rd_en,
    input  logic [AW-1:0]         rd_addr,
    input  logic [DW-1:0]         rf_rdata,
    input  logic [DW*DEPTH-1:0]   stage_wdata,
    output logic [DW-1:0]         op_rdata,
    output logic                  hazard
);

    logic          hit_s;
    logic          win_ready_s;
    logic [DW-1:0] win_data_s;

    // Priority search: scan oldest to youngest so the youngest match is the last one kept.
    always_comb begin
        hit_s       = 1'b0;
        win_ready_s = 1'b0;
        win_data_s  = {DW{1'b0}};
        for (int k = DEPTH; k >= 1; k--) begin
            if (entries[k-1].v && entries[k-1].we && (entries[k-1].waddr == rd_addr) &&
                (rd_addr != {AW{1'b0}}) && rd_en) begin
                hit_s       = 1'b1;
                win_ready_s = (3'(k) >= entries[k-1].rdy);
                win_data_s  = stage_wdata[(k-1)*DW +: DW];
            end else begin
                hit_s = hit_s;
            end
        end
    end

    // Operand select and hazard flag; an unready youngest match blocks any older one.
    always_comb begin
        op_rdata = rf_rdata;
        hazard   = 1'b0;
        if (hit_s && win_ready_s) begin
            op_rdata = win_data_s;
        end else if (hit_s) begin
            hazard = 1'b1;
        end else begin
            op_rdata = rf_rdata;
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks destination registers of instructions in the
// post-decode stages, forwards operands to the ID stage and requests an ID
// stall on load-use hazards.
// Ports:
//   clk, rst            clock; synchronous active-low reset
//   adv, flush          pipeline advance from EX; kill ID and stage 1
//   iss_*               instruction currently in ID
//   rd_en, rd_addr      per-port read enable / source register
//   rf_rdata            per-port register-file data
//   stage_wdata         per-stage result data (slice k-1 = stage k)
//   op_rdata            per-port forwarded operand
//   stallreq            combinational ID hold request
//   stall_cnt           saturating count of stalled cycles
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int DEPTH = 3,
    parameter int NRD   = 2,
    parameter int DW    = 32,
    parameter int CNTW  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  adv,
    input  logic                  flush,
    input  logic                  iss_valid,
    input  logic                  iss_we,
    input  logic [AW-1:0]         iss_waddr,
    input  logic [RDYW-1:0]       iss_rdy,
    input  logic [NRD-1:0]        rd_en,
    input  logic [AW*NRD-1:0]     rd_addr,
    input  logic [DW*NRD-1:0]     rf_rdata,
    input  logic [DW*DEPTH-1:0]   stage_wdata,
    output logic [DW*NRD-1:0]     op_rdata,
    output logic                  stallreq,
    output logic [CNTW-1:0]       stall_cnt
);

    entry_t [DEPTH-1:0] ent_r;
    entry_t [DEPTH-1:0] ent_q_s;
    entry_t             new_ent_s;
    logic [NRD-1:0]     hazard_s;
    logic               issue_s;
    logic [CNTW-1:0]    stall_cnt_r;

    // Entries seen by the ports are masked while reset is held so the
    // outputs fall back to register-file data before the first clean edge.
    always_comb begin
        ent_q_s = ent_r;
        for (int k = 0; k < DEPTH; k++) begin
            ent_q_s[k].v = ent_r[k].v & rst;
        end
    end

    genvar i;
    generate
        for (i = 0; i < NRD; i++) begin : g_port
            hs_fwd_port #(
                .DEPTH (DEPTH),
                .DW    (DW)
            ) u_port (
                .entries     (ent_q_s),
                .rd_en       (rd_en[i]),
                .rd_addr     (rd_addr[i*AW +: AW]),
                .rf_rdata    (rf_rdata[i*DW +: DW]),
                .stage_wdata (stage_wdata),
                .op_rdata    (op_rdata[i*DW +: DW]),
                .hazard      (hazard_s[i])
            );
        end
    endgenerate

    assign stallreq  = (|hazard_s) & iss_valid & ~flush;
    assign issue_s   = iss_valid & ~stallreq & ~flush;
    assign stall_cnt = stall_cnt_r;

    // Entry loaded into stage 1 when the ID instruction is allowed to issue.
    always_comb begin
        new_ent_s.v     = 1'b1;
        new_ent_s.we    = iss_we;
        new_ent_s.waddr = iss_waddr;
        new_ent_s.rdy   = norm_rdy(iss_rdy, 3'(DEPTH));
    end

    // Entry pipeline shift/hold and saturating stall counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ent_r       <= '0;
            stall_cnt_r <= {CNTW{1'b0}};
        end else begin
            if (adv) begin
                for (int k = DEPTH - 1; k >= 1; k--) begin
                    ent_r[k] <= ent_r[k-1];
                end
                if (issue_s) begin
                    ent_r[0] <= new_ent_s;
                end else begin
                    ent_r[0] <= '0;
                end
            end else if (flush) begin
                ent_r[0].v <= 1'b0;
            end else begin
                ent_r <= ent_r;
            end

            if (stallreq && (stall_cnt_r != {CNTW{1'b1}})) begin
                stall_cnt_r <= stall_cnt_r + {{(CNTW-1){1'b0}}, 1'b1};
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard (DEPTH=3, NRD=2, DW=32) with a
// second CNTW=4 instance sharing all stimulus for the saturation case.
module tb_hazard_scoreboard;

    logic        clk;
    logic        rst;
    logic        adv;
    logic        flush;
    logic        iss_valid;
    logic        iss_we;
    logic [4:0]  iss_waddr;
    logic [2:0]  iss_rdy;
    logic [1:0]  rd_en;
    logic [4:0]  ra0, ra1;
    logic [31:0] rf0, rf1;
    logic [31:0] sw0, sw1, sw2;
    logic [63:0] op_rdata;
    logic        stallreq;
    logic [15:0] stall_cnt;
    logic [63:0] op4;
    logic        stallreq4;
    logic [3:0]  cnt4;

    int total = 0;
    int bad   = 0;

    hazard_scoreboard #(.DEPTH(3), .NRD(2), .DW(32), .CNTW(16)) dut (
        .clk(clk), .rst(rst), .adv(adv), .flush(flush),
        .iss_valid(iss_valid), .iss_we(iss_we), .iss_waddr(iss_waddr), .iss_rdy(iss_rdy),
        .rd_en(rd_en), .rd_addr({ra1, ra0}), .rf_rdata({rf1, rf0}),
        .stage_wdata({sw2, sw1, sw0}),
        .op_rdata(op_rdata), .stallreq(stallreq), .stall_cnt(stall_cnt)
    );

    hazard_scoreboard #(.DEPTH(3), .NRD(2), .DW(32), .CNTW(4)) dut4 (
        .clk(clk), .rst(rst), .adv(adv), .flush(flush),
        .iss_valid(iss_valid), .iss_we(iss_we), .iss_waddr(iss_waddr), .iss_rdy(iss_rdy),
        .rd_en(rd_en), .rd_addr({ra1, ra0}), .rf_rdata({rf1, rf0}),
        .stage_wdata({sw2, sw1, sw0}),
        .op_rdata(op4), .stallreq(stallreq4), .stall_cnt(cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one instruction with reads off, then leave a non-writing NOP in ID.
    task automatic issue(input logic we, input logic [4:0] waddr, input logic [2:0] rdy);
        rd_en     = 2'b00;
        iss_valid = 1'b1;
        iss_we    = we;
        iss_waddr = waddr;
        iss_rdy   = rdy;
        tick();
        iss_we    = 1'b0;
        iss_waddr = 5'd0;
        iss_rdy   = 3'd1;
    endtask

    initial begin
        rst = 1'b0; adv = 1'b1; flush = 1'b0;
        iss_valid = 1'b1; iss_we = 1'b1; iss_waddr = 5'd3; iss_rdy = 3'd1;
        rd_en = 2'b11; ra0 = 5'd3; ra1 = 5'd5;
        rf0 = 32'h1111_0000; rf1 = 32'h2222_0000;
        sw0 = 32'h0000_1234; sw1 = 32'h0000_5678; sw2 = 32'h0000_9abc;

        // Reset: outputs fall back to the register file, counter clear
        #1;
        chk("rst_stall_pre", {31'd0, stallreq}, 32'd0);
        chk("rst_op0_pre", op_rdata[31:0], rf0);
        tick(); tick();
        chk("rst_stall", {31'd0, stallreq}, 32'd0);
        chk("rst_cnt", {16'd0, stall_cnt}, 32'd0);
        chk("rst_op1", op_rdata[63:32], rf1);
        rst = 1'b1;
        #1;
        chk("rst_override_issue", op_rdata[31:0], rf0);
        iss_we = 1'b0;

        // ALU result bypassed from EX, then MEM, then WB, then retired
        issue(1'b1, 5'd3, 3'd1);
        rd_en = 2'b11; ra0 = 5'd3; ra1 = 5'd0;
        #1;
        chk("alu_ex_op0", op_rdata[31:0], 32'h0000_1234);
        chk("alu_ex_stall", {31'd0, stallreq}, 32'd0);
        chk("r0_port1", op_rdata[63:32], rf1);
        tick();
        chk("alu_mem_op0", op_rdata[31:0], 32'h0000_5678);
        tick();
        chk("alu_wb_op0", op_rdata[31:0], 32'h0000_9abc);
        tick();
        chk("alu_retired_op0", op_rdata[31:0], rf0);

        // Load-use: one stall cycle, then bypass from MEM on both ports
        issue(1'b1, 5'd5, 3'd2);
        rd_en = 2'b11; ra0 = 5'd5; ra1 = 5'd5;
        #1;
        chk("lu_stall", {31'd0, stallreq}, 32'd1);
        chk("lu_op0_rf", op_rdata[31:0], rf0);
        chk("lu_op1_rf", op_rdata[63:32], rf1);
        tick();
        chk("lu_cnt", {16'd0, stall_cnt}, 32'd1);
        chk("lu_stall_clear", {31'd0, stallreq}, 32'd0);
        chk("lu_op0_mem", op_rdata[31:0], sw1);
        chk("lu_op1_mem", op_rdata[63:32], sw1);

        // Youngest writer wins
        issue(1'b1, 5'd7, 3'd1);
        issue(1'b1, 5'd7, 3'd1);
        sw0 = 32'h0000_AAAA; sw1 = 32'h0000_BBBB;
        rd_en = 2'b01; ra0 = 5'd7;
        #1;
        chk("youngest_op0", op_rdata[31:0], 32'h0000_AAAA);
        chk("youngest_stall", {31'd0, stallreq}, 32'd0);

        // Older ready writer must not bypass a younger unready load
        issue(1'b1, 5'd9, 3'd1);
        issue(1'b1, 5'd9, 3'd2);
        rd_en = 2'b01; ra0 = 5'd9;
        #1;
        chk("no_bypass_stall", {31'd0, stallreq}, 32'd1);
        chk("no_bypass_op0", op_rdata[31:0], rf0);
        flush = 1'b1;
        #1;
        chk("flush_gates_stall", {31'd0, stallreq}, 32'd0);
        flush = 1'b0;
        #1;
        tick();
        chk("no_bypass_cnt", {16'd0, stall_cnt}, 32'd2);
        chk("no_bypass_mem", op_rdata[31:0], 32'h0000_BBBB);

        // Register 0 never matches
        issue(1'b1, 5'd0, 3'd2);
        rd_en = 2'b11; ra0 = 5'd0; ra1 = 5'd0; rf0 = 32'd0; rf1 = 32'h0000_0033;
        #1;
        chk("r0_op0", op_rdata[31:0], 32'd0);
        chk("r0_op1", op_rdata[63:32], 32'h0000_0033);
        chk("r0_stall", {31'd0, stallreq}, 32'd0);
        rf0 = 32'h1111_0000; rf1 = 32'h2222_0000;

        // Ready stage 0 behaves as EX
        issue(1'b1, 5'd4, 3'd0);
        rd_en = 2'b01; ra0 = 5'd4;
        #1;
        chk("rdy0_op0", op_rdata[31:0], 32'h0000_AAAA);
        chk("rdy0_stall", {31'd0, stallreq}, 32'd0);

        // Ready stage 7 behaves as WB: two stall cycles then bypass from WB
        issue(1'b1, 5'd6, 3'd7);
        rd_en = 2'b01; ra0 = 5'd6;
        #1;
        chk("rdy7_stall_s1", {31'd0, stallreq}, 32'd1);
        tick();
        chk("rdy7_stall_s2", {31'd0, stallreq}, 32'd1);
        tick();
        chk("rdy7_stall_s3", {31'd0, stallreq}, 32'd0);
        chk("rdy7_op0_wb", op_rdata[31:0], sw2);
        chk("rdy7_cnt", {16'd0, stall_cnt}, 32'd4);

        // Flush while advancing: the ID instruction becomes a bubble
        rd_en = 2'b00;
        iss_valid = 1'b1; iss_we = 1'b1; iss_waddr = 5'd8; iss_rdy = 3'd1; flush = 1'b1;
        tick();
        flush = 1'b0; iss_we = 1'b0;
        rd_en = 2'b01; ra0 = 5'd8;
        #1;
        chk("flush_adv_op0", op_rdata[31:0], rf0);

        // Flush while held: stage 1 is invalidated in place
        issue(1'b1, 5'd10, 3'd1);
        adv = 1'b0; flush = 1'b1;
        tick();
        adv = 1'b1; flush = 1'b0;
        rd_en = 2'b01; ra0 = 5'd10;
        #1;
        chk("flush_hold_op0", op_rdata[31:0], rf0);

        // Downstream stall with a pending load-use, then reset mid-sequence
        issue(1'b1, 5'd12, 3'd2);
        adv = 1'b0;
        rd_en = 2'b01; ra0 = 5'd12;
        #1;
        chk("frz_stall_0", {31'd0, stallreq}, 32'd1);
        tick();
        chk("frz_stall_1", {31'd0, stallreq}, 32'd1);
        tick();
        chk("frz_stall_2", {31'd0, stallreq}, 32'd1);
        tick();
        chk("frz_stall_3", {31'd0, stallreq}, 32'd1);
        chk("frz_cnt", {16'd0, stall_cnt}, 32'd7);
        rst = 1'b0;
        #1;
        chk("mid_rst_stall", {31'd0, stallreq}, 32'd0);
        chk("mid_rst_op0", op_rdata[31:0], rf0);
        tick();
        chk("mid_rst_cnt", {16'd0, stall_cnt}, 32'd0);
        rst = 1'b1;
        #1;
        chk("post_rst_stall", {31'd0, stallreq}, 32'd0);
        chk("post_rst_op0", op_rdata[31:0], rf0);
        adv = 1'b1;

        // Long stall: 16-bit counter reaches 20, 4-bit counter pins at 15
        issue(1'b1, 5'd13, 3'd2);
        adv = 1'b0;
        rd_en = 2'b01; ra0 = 5'd13;
        repeat (20) tick();
        chk("sat_cnt16", {16'd0, stall_cnt}, 32'd20);
        chk("sat_cnt4", {28'd0, cnt4}, 32'd15);
        chk("sat_stall4", {31'd0, stallreq4}, 32'd1);
        chk("sat_op4_p0", op4[31:0], rf0);
        chk("sat_op4_p1", op4[63:32], rf1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
